// File: rtl/sprite_compositor.sv
// Per-sprite ROM address generation and fixed-priority palette compositing for the VGA pixel path.
// SPRITES_EN -> RGB latency is two VGA_CLK cycles (ROM read, then palette lookup).
module sprite_compositor #(
    parameter int          AW        = 17,
    parameter int          BG_AREA   = 129600,
    parameter int          BTN_AREA  = 28224,
    parameter int          LOSE_AREA = 50400,
    parameter int          WIN_AREA  = 43200,
    parameter int          PWR_AREA  = 400,
    parameter logic [23:0] FILL_RGB  = 24'h000000
) (
    input  logic            VGA_CLK,
    input  logic            RESET,
    input  logic            VGA_VS,
    input  logic [7:0]      SPRITES_EN,
    output logic [8*AW-1:0] ROM_ADDR,
    input  logic [31:0]     ROM_DATA,
    output logic [23:0]     RGB
);

    // Index k matches SPRITES_EN bit k: 0 = PWR ... 7 = BG.
    localparam int AREA [8] = '{PWR_AREA, WIN_AREA, LOSE_AREA, BTN_AREA,
                                BTN_AREA, BTN_AREA, BTN_AREA, BG_AREA};

    logic [AW-1:0] cnt [8];
    logic          vs_d;
    logic [7:0]    en_d;
    logic          fall;
    logic          any_opaque;
    logic [3:0]    win_idx;
    logic [23:0]   rgb_next;

    function automatic logic [23:0] palette(input logic [3:0] idx);
        case (idx)
            4'd1:    palette = 24'h0000FF;
            4'd2:    palette = 24'h00FF00;
            4'd3:    palette = 24'hFF0000;
            4'd4:    palette = 24'hFFFF00;
            4'd5:    palette = 24'hFFFFFF;
            4'd6:    palette = 24'h808080;
            default: palette = 24'h000000;
        endcase
    endfunction

    assign fall = vs_d & ~VGA_VS;

    for (genvar g = 0; g < 8; g++) begin : g_addr
        assign ROM_ADDR[g*AW +: AW] = cnt[g];
    end

    // Walk from lowest to highest priority so the last opaque hit wins.
    always_comb begin
        any_opaque = 1'b0;
        win_idx    = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (en_d[k] && (ROM_DATA[4*k +: 4] != 4'd0)) begin
                any_opaque = 1'b1;
                win_idx    = ROM_DATA[4*k +: 4];
            end
        end
        rgb_next = any_opaque ? palette(win_idx) : FILL_RGB;
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            vs_d <= 1'b1;
            en_d <= 8'd0;
            RGB  <= 24'd0;
            for (int k = 0; k < 8; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            vs_d <= VGA_VS;
            en_d <= SPRITES_EN;
            RGB  <= rgb_next;
            // Frame restart beats any increment in the same cycle.
            for (int k = 0; k < 8; k++) begin
                if (fall) begin
                    cnt[k] <= '0;
                end else if (SPRITES_EN[k]) begin
                    if (cnt[k] == AW'(AREA[k] - 1)) begin
                        cnt[k] <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reference model of counters and compositing,
// expected RGB queued at drive time and compared after the edge that produces it.
module tb_sprite_compositor;

    localparam int AW = 17;

    logic            VGA_CLK;
    logic            RESET;
    logic            VGA_VS;
    logic [7:0]      SPRITES_EN;
    logic [8*AW-1:0] ROM_ADDR;
    logic [31:0]     ROM_DATA;
    logic [23:0]     RGB;

    sprite_compositor dut (
        .VGA_CLK    (VGA_CLK),
        .RESET      (RESET),
        .VGA_VS     (VGA_VS),
        .SPRITES_EN (SPRITES_EN),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .RGB        (RGB)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q [$];

    int          areas [8] = '{400, 43200, 50400, 28224, 28224, 28224, 28224, 129600};
    int          m_addr [8];
    logic [7:0]  m_en_d = 8'd0;
    logic        m_vs_d = 1'b1;

    function automatic logic [23:0] ref_color(input logic [3:0] idx);
        case (idx)
            4'd1:    ref_color = 24'h0000FF;
            4'd2:    ref_color = 24'h00FF00;
            4'd3:    ref_color = 24'hFF0000;
            4'd4:    ref_color = 24'hFFFF00;
            4'd5:    ref_color = 24'hFFFFFF;
            4'd6:    ref_color = 24'h808080;
            default: ref_color = 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model_rgb(input logic [7:0] en, input logic [31:0] data);
        logic [3:0] idx;
        model_rgb = 24'h000000;
        for (int k = 0; k < 8; k++) begin
            idx = data[4*k +: 4];
            if (en[k] && idx != 4'd0) begin
                return ref_color(idx);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] addr_of(input int k);
        addr_of = 32'(ROM_ADDR[k*AW +: AW]);
    endfunction

    task automatic step(input logic [7:0] en, input logic [31:0] data,
                        input logic vs, input logic rst);
        logic        fall;
        logic [23:0] e;
        SPRITES_EN = en;
        ROM_DATA   = data;
        VGA_VS     = vs;
        RESET      = rst;
        e = rst ? 24'h000000 : model_rgb(m_en_d, data);
        exp_q.push_back(e);
        @(posedge VGA_CLK);
        if (rst) begin
            for (int k = 0; k < 8; k++) m_addr[k] = 0;
            m_en_d = 8'd0;
            m_vs_d = 1'b1;
        end else begin
            fall = m_vs_d & ~vs;
            for (int k = 0; k < 8; k++) begin
                if (fall) m_addr[k] = 0;
                else if (en[k]) m_addr[k] = (m_addr[k] == areas[k] - 1) ? 0 : m_addr[k] + 1;
            end
            m_en_d = en;
            m_vs_d = vs;
        end
        #1;
        chk("rgb", 32'(RGB), 32'(exp_q.pop_front()));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("addr%0d", k), addr_of(k), 32'(m_addr[k]));
        end
    endtask

    initial begin
        RESET = 1'b1; VGA_VS = 1'b1; SPRITES_EN = 8'd0; ROM_DATA = 32'd0;

        // Reset, then idle.
        step(8'h00, 32'h0, 1'b1, 1'b1);
        step(8'h00, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(8'h00, 32'h0, 1'b1, 1'b0);
        chk("idle_rgb", 32'(RGB), 32'h0);

        // BG only, index 1 -> blue two cycles after enable rises.
        step(8'h80, 32'h1000_0000, 1'b1, 1'b0);
        chk("bg_first_fill", 32'(RGB), 32'h0);
        chk("bg_addr1", addr_of(7), 32'd1);
        step(8'h80, 32'h1000_0000, 1'b1, 1'b0);
        chk("bg_blue", 32'(RGB), 32'h0000FF);
        for (int i = 0; i < 4; i++) step(8'h80, 32'h1000_0000, 1'b1, 1'b0);
        chk("bg_addr6", addr_of(7), 32'd6);

        // BG idx 2 under PWR idx 3 -> red; PWR transparent -> green.
        for (int i = 0; i < 3; i++) step(8'h81, 32'h2000_0003, 1'b1, 1'b0);
        chk("pwr_over_bg", 32'(RGB), 32'hFF0000);
        for (int i = 0; i < 3; i++) step(8'h81, 32'h2000_0000, 1'b1, 1'b0);
        chk("pwr_transparent", 32'(RGB), 32'h00FF00);

        // Random overlap across all sprites.
        for (int i = 0; i < 40; i++)
            step(8'($urandom_range(0, 255)), $urandom(), 1'b1, 1'b0);

        // PWR wrap from a clean start.
        step(8'h00, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 399; i++) step(8'h01, 32'h5, 1'b1, 1'b0);
        chk("pwr_399", addr_of(0), 32'd399);
        step(8'h01, 32'h5, 1'b1, 1'b0);
        chk("pwr_wrap", addr_of(0), 32'd0);
        chk("pwr_white", 32'(RGB), 32'hFFFFFF);

        // VS fall clears counter in the same cycle as an enabled BG.
        step(8'h00, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5000; i++) step(8'h80, 32'h6000_0000, 1'b1, 1'b0);
        chk("bg_5000", addr_of(7), 32'd5000);
        step(8'h80, 32'h6000_0000, 1'b0, 1'b0);
        chk("vs_clear", addr_of(7), 32'd0);
        step(8'h80, 32'h6000_0000, 1'b0, 1'b0);
        chk("vs_low_count", addr_of(7), 32'd1);
        step(8'h80, 32'h6000_0000, 1'b1, 1'b0);
        chk("grey", 32'(RGB), 32'h808080);

        // Mid-flight reset drops pixels and counters.
        for (int i = 0; i < 5; i++) step(8'hFF, 32'h4444_4444, 1'b1, 1'b0);
        step(8'hFF, 32'h4444_4444, 1'b1, 1'b1);
        chk("rst_rgb", 32'(RGB), 32'h0);
        chk("rst_addr3", addr_of(3), 32'd0);
        step(8'h00, 32'h4444_4444, 1'b1, 1'b0);
        chk("rst_no_stale", 32'(RGB), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
